// File: rtl/stage_e_mdu.sv
// Stage-E multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU into private HI/LO,
// plus combinational MFHI/MFLO reads and single-cycle MTHI/MTLO writes.
module stage_e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDURes
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;
  logic            pend_we_q, pend_we_d;

  logic               is_mul, is_div;
  logic [63:0]        res;
  logic               res_we;
  logic signed [63:0] a_ext, b_ext;
  logic signed [31:0] sa, sb;

  assign is_mul = (MDUOp == OpMult) || (MDUOp == OpMultu);
  assign is_div = (MDUOp == OpDiv) || (MDUOp == OpDivu);
  assign Busy   = (cnt_q != '0);
  assign Start  = (is_mul || is_div) && !Busy;
  assign HI     = hi_q;
  assign LO     = lo_q;

  assign a_ext = {{32{A[31]}}, A};
  assign b_ext = {{32{B[31]}}, B};
  assign sa    = A;
  assign sb    = B;

  always_comb begin
    MDURes = 32'h0;
    if (MDUOp == OpMfhi) begin
      MDURes = hi_q;
    end else if (MDUOp == OpMflo) begin
      MDURes = lo_q;
    end
  end

  // Result computed at issue; divide-by-zero suppresses the write-back.
  always_comb begin
    res    = 64'h0;
    res_we = 1'b1;
    case (MDUOp)
      OpMult:  res = a_ext * b_ext;
      OpMultu: res = {32'h0, A} * {32'h0, B};
      OpDiv: begin
        if (B == 32'h0) begin
          res_we = 1'b0;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res = {32'h0, 32'h8000_0000};
        end else begin
          res = {sa % sb, sa / sb};
        end
      end
      OpDivu: begin
        if (B == 32'h0) begin
          res_we = 1'b0;
        end else begin
          res = {A % B, A / B};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    if (Start) begin
      cnt_d     = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
      pend_d    = res;
      pend_we_d = res_we;
    end else if (Busy) begin
      // Any MDU op arriving while busy falls through here and is ignored.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1) && pend_we_q) begin
        hi_d = pend_q[63:32];
        lo_d = pend_q[31:0];
      end
    end else if (MDUOp == OpMthi) begin
      hi_d = A;
    end else if (MDUOp == OpMtlo) begin
      lo_d = A;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_q    <= 64'h0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_stage_e_mdu.sv
// Randomised self-checking bench for stage_e_mdu against an arithmetic HI/LO model.
module tb_stage_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDURes;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] hi_m, lo_m;

  stage_e_mdu #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO),
    .MDURes(MDURes)
  );

  always #5 clk = ~clk;

  function automatic int op_cycles(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 5;
    if (op == 4'd3 || op == 4'd4) return 10;
    return 0;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin p = {32'h0, a} * {32'h0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
  endtask

  // Applies one op for one cycle, then follows the busy window and checks the outcome.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] old_hi, old_lo, exp_res;
    logic exp_start;
    n = op_cycles(op);
    exp_start = (n != 0);
    exp_res = (op == 4'd5) ? hi_m : (op == 4'd6) ? lo_m : 32'h0;
    old_hi = hi_m;
    old_lo = lo_m;
    MDUOp = op; A = a; B = b;
    @(negedge clk);
    vectors++;
    if (Start !== exp_start || MDURes !== exp_res)
      $display("FAIL issue op=%0d: Start=%b MDURes=%h, want Start=%b MDURes=%h",
               op, Start, MDURes, exp_start, exp_res);
    if (Start !== exp_start || MDURes !== exp_res) errors++;
    @(posedge clk); #1;
    model_op(op, a, b);
    for (int k = 0; k < n; k++) begin
      MDUOp = 4'($urandom_range(1, 4)); A = $urandom; B = $urandom;
      @(negedge clk);
      vectors++;
      if (Busy !== 1'b1 || Start !== 1'b0 || HI !== old_hi || LO !== old_lo) begin
        errors++;
        $display("FAIL busy op=%0d cyc=%0d: Busy=%b Start=%b HI=%h LO=%h, want 1 0 %h %h",
                 op, k, Busy, Start, HI, LO, old_hi, old_lo);
      end
      @(posedge clk); #1;
    end
    MDUOp = 4'd0;
    @(negedge clk);
    vectors++;
    if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m || MDURes !== 32'h0) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h: Busy=%b HI=%h LO=%h MDURes=%h, want 0 %h %h 0",
               op, a, b, Busy, HI, LO, MDURes, hi_m, lo_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; MDUOp = 4'd0; A = 32'h0; B = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1; MDUOp = 4'd5;
    @(negedge clk);
    hi_m = 32'h0; lo_m = 32'h0;
    vectors++;
    if (Busy !== 1'b0 || Start !== 1'b0 || HI !== 32'h0 || LO !== 32'h0 || MDURes !== 32'h0) begin
      errors++;
      $display("FAIL reset: Busy=%b Start=%b HI=%h LO=%h MDURes=%h, want all 0",
               Busy, Start, HI, LO, MDURes);
    end
    @(posedge clk); #1 MDUOp = 4'd0;
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2);
    vectors++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mult_vec: HI=%h LO=%h, want ffffffff fffffffe", HI, LO);
    end
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2);
    vectors++;
    if (HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_vec: HI=%h LO=%h, want 00000001 fffffffe", HI, LO);
    end
    run_op(4'd6, 32'h0, 32'h0);
    run_op(4'd5, 32'h0, 32'h0);
  endtask

  task automatic test_div;
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    vectors++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_vec: HI=%h LO=%h, want ffffffff fffffffd", HI, LO);
    end
    run_op(4'd4, 32'd7, 32'd2);
    vectors++;
    if (HI !== 32'd1 || LO !== 32'd3) begin
      errors++;
      $display("FAIL divu_vec: HI=%h LO=%h, want 1 3", HI, LO);
    end
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    vectors++;
    if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf: HI=%h LO=%h, want 0 80000000", HI, LO);
    end
  endtask

  task automatic test_mt_divzero;
    run_op(4'd7, 32'h1234, 32'h0);
    run_op(4'd8, 32'h5678, 32'h0);
    run_op(4'd4, 32'hCAFE, 32'h0);
    run_op(4'd3, 32'hBEEF, 32'h0);
    vectors++;
    if (HI !== 32'h1234 || LO !== 32'h5678) begin
      errors++;
      $display("FAIL divzero: HI=%h LO=%h, want 1234 5678", HI, LO);
    end
  endtask

  task automatic test_busy_ignore;
    logic [3:0] op;
    MDUOp = 4'd1; A = 32'h0001_0003; B = 32'hFFFF_FFF0;
    @(posedge clk); #1;
    model_op(4'd1, 32'h0001_0003, 32'hFFFF_FFF0);
    for (int k = 0; k < 5; k++) begin
      op = (k == 1) ? 4'd8 : 4'($urandom_range(0, 5) < 4 ? $urandom_range(1, 4)
                                                         : $urandom_range(7, 8));
      MDUOp = op; A = 32'hDEAD; B = $urandom;
      @(negedge clk);
      vectors++;
      if (Start !== 1'b0 || Busy !== 1'b1) begin
        errors++;
        $display("FAIL ignore cyc=%0d op=%0d: Start=%b Busy=%b, want 0 1", k, op, Start, Busy);
      end
      @(posedge clk); #1;
    end
    MDUOp = 4'd0;
    @(negedge clk);
    vectors++;
    if (Busy !== 1'b0 || HI !== hi_m || LO !== lo_m) begin
      errors++;
      $display("FAIL ignore_result: Busy=%b HI=%h LO=%h, want 0 %h %h", Busy, HI, LO, hi_m, lo_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort;
    run_op(4'd7, 32'hAAAA_5555, 32'h0);
    MDUOp = 4'd3; A = 32'd1000; B = 32'd7;
    @(posedge clk); #1 MDUOp = 4'd0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    hi_m = 32'h0; lo_m = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
        errors++;
        $display("FAIL abort cyc=%0d: Busy=%b HI=%h LO=%h, want 0 0 0", k, Busy, HI, LO);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 :
           ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = $signed(a) >>> 20;
      run_op(op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
